// File: rtl/data_mem_resp.sv
// Word-organised data RAM responder: accepts one request, waits LATENCY cycles, then gives a one-cycle response.
// Optional macro DMEM_BYTE_MASK_EN enables byte-masked stores through be_i4.
module data_mem_resp #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i32,
    input  logic [31:0] wdata_i32,
    input  logic [3:0]  be_i4,
    output logic        ready_o,
    output logic        resp_valid_o,
    output logic [31:0] rdata_o32,
    output logic        err_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_cnt;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_be;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic [31:0]   r_mem [DEPTH];

    logic          w_accept;
    logic          w_enter_done;
    logic          w_we;
    logic          w_err;
    logic          w_wr_en;
    logic          w_unused_be;
    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;
    logic [31:0]   w_wmask;
    logic [31:0]   w_rd_word;
    logic [3:0]    w_be;
    logic [AW-1:0] w_idx;

    assign w_accept     = (r_state == S_IDLE) && req_i;
    assign w_enter_done = (w_accept && (LATENCY == 0)) || ((r_state == S_WAIT) && (r_cnt == 4'd1));

    // With LATENCY=0 the access happens on the accepting edge, so use the live inputs.
    assign w_we    = (r_state == S_IDLE) ? we_i      : r_we;
    assign w_addr  = (r_state == S_IDLE) ? addr_i32  : r_addr;
    assign w_wdata = (r_state == S_IDLE) ? wdata_i32 : r_wdata;
    assign w_be    = (r_state == S_IDLE) ? be_i4     : r_be;

    assign w_err     = (w_addr[1:0] != 2'b00) || (w_addr[31:2] >= 30'(DEPTH));
    assign w_idx     = w_addr[AW+1:2];
    assign w_rd_word = r_mem[w_idx];
    assign w_wr_en   = reset_ni && w_enter_done && w_we && !w_err;

`ifdef DMEM_BYTE_MASK_EN
    assign w_wmask     = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
    assign w_unused_be = 1'b0;
`else
    assign w_wmask     = '1;
    assign w_unused_be = ^w_be;
`endif

    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_mem[w_idx] <= (r_mem[w_idx] & ~w_wmask) | (w_wdata & w_wmask);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_we    <= we_i;
            r_addr  <= addr_i32;
            r_wdata <= wdata_i32;
            r_be    <= be_i4;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_i) w_next = (LATENCY == 0) ? S_DONE : S_WAIT;
            S_WAIT:  if (r_cnt == 4'd1) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ready_o      = (r_state == S_IDLE);
        resp_valid_o = (r_state == S_DONE);
    end

    // Response data exists only during DONE; every other cycle it is forced to zero.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt <= 4'(LATENCY);
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_done) begin
                r_err   <= w_err;
                r_rdata <= (w_we || w_err) ? 32'd0 : w_rd_word;
            end else begin
                r_err   <= 1'b0;
                r_rdata <= 32'd0;
            end
        end
    end

    assign rdata_o32 = r_rdata;
    assign err_o     = r_err;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: LATENCY=2 and LATENCY=0 instances, table vectors plus multi-cycle sequences.
module tb_data_mem_resp;
    logic        clk;
    logic        reset_ni;
    logic        req2, req0;
    logic        we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        rdy2, vld2, err2;
    logic [31:0] rd2;
    logic        rdy0, vld0, err0;
    logic [31:0] rd0;

    int n_chk;
    int n_fail;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

`ifdef DMEM_BYTE_MASK_EN
    localparam logic [31:0] EXP_MASKED  = 32'h11BB33DD;
    localparam logic [31:0] EXP_ZERO_BE = 32'h11BB33DD;
`else
    localparam logic [31:0] EXP_MASKED  = 32'hAABBCCDD;
    localparam logic [31:0] EXP_ZERO_BE = 32'h99999999;
`endif

    data_mem_resp #(.DEPTH(64), .LATENCY(2)) u_dut2 (
        .clk_i(clk), .reset_ni(reset_ni), .req_i(req2), .we_i(we),
        .addr_i32(addr), .wdata_i32(wdata), .be_i4(be),
        .ready_o(rdy2), .resp_valid_o(vld2), .rdata_o32(rd2), .err_o(err2)
    );

    data_mem_resp #(.DEPTH(64), .LATENCY(0)) u_dut0 (
        .clk_i(clk), .reset_ni(reset_ni), .req_i(req0), .we_i(we),
        .addr_i32(addr), .wdata_i32(wdata), .be_i4(be),
        .ready_o(rdy0), .resp_valid_o(vld0), .rdata_o32(rd0), .err_o(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    // Starts at a negedge with the target idle; returns at a negedge one cycle after the response.
    task automatic xact(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output logic [31:0] rd, output logic er,
                        output int lat, output logic rdy1, output logic idle_ok);
        we = w; addr = a; wdata = d; be = b;
        if (sel) req2 = 1'b1; else req0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req2 = 1'b0; req0 = 1'b0;
        lat  = 1;
        rdy1 = sel ? rdy2 : rdy0;
        while (!(sel ? vld2 : vld0) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = sel ? rd2 : rd0;
        er = sel ? err2 : err0;
        @(negedge clk);
        if (sel) idle_ok = rdy2 && !vld2 && (rd2 == 32'd0) && !err2;
        else     idle_ok = rdy0 && !vld0 && (rd0 == 32'd0) && !err0;
    endtask

    initial begin
        vec_t        vecs[19];
        logic [31:0] rd;
        logic        er, rdy1, idle_ok;
        int          lat, nresp, bad, tail;
        logic        exp_v;

        n_chk = 0; n_fail = 0;
        req2 = 0; req0 = 0; we = 0; addr = 0; wdata = 0; be = 0;
        reset_ni = 1'b1;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0000, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 32'h0000_00FC, 32'h11111111, 4'hF, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 32'h0000_00FC, 32'h0,        4'hF, 32'h11111111, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0102, 32'h0,        4'hF, 32'h0,        1'b1};
        vecs[6]  = '{1'b0, 32'h0000_0100, 32'h0,        4'hF, 32'h0,        1'b1};
        vecs[7]  = '{1'b1, 32'h0000_0100, 32'h55555555, 4'hF, 32'h0,        1'b1};
        vecs[8]  = '{1'b1, 32'h0000_0013, 32'h77777777, 4'hF, 32'h0,        1'b1};
        vecs[9]  = '{1'b0, 32'h8000_0010, 32'h0,        4'hF, 32'h0,        1'b1};
        vecs[10] = '{1'b0, 32'h0000_0000, 32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
        vecs[11] = '{1'b0, 32'h0000_0010, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
        vecs[12] = '{1'b0, 32'h0000_00FC, 32'h0,        4'hF, 32'h11111111, 1'b0};
        vecs[13] = '{1'b1, 32'h0000_0020, 32'h0BADF00D, 4'hF, 32'h0,        1'b0};
        vecs[14] = '{1'b1, 32'h0000_0040, 32'h11223344, 4'hF, 32'h0,        1'b0};
        vecs[15] = '{1'b1, 32'h0000_0040, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
        vecs[16] = '{1'b0, 32'h0000_0040, 32'h0,        4'hF, EXP_MASKED,   1'b0};
        vecs[17] = '{1'b1, 32'h0000_0040, 32'h99999999, 4'h0, 32'h0,        1'b0};
        vecs[18] = '{1'b0, 32'h0000_0040, 32'h0,        4'hF, EXP_ZERO_BE,  1'b0};

        #2 reset_ni = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset ready", 32'(rdy2), 32'd1);
        chk("reset resp_valid", 32'(vld2), 32'd0);
        chk("reset rdata", rd2, 32'd0);
        chk("reset err", 32'(err2), 32'd0);
        chk("reset0 ready", 32'(rdy0), 32'd1);
        chk("reset0 resp_valid", 32'(vld0), 32'd0);
        reset_ni = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 19; i++) begin
            xact(1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat, rdy1, idle_ok);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'd3);
            chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d busy", i), 32'(rdy1), 32'd0);
            chk($sformatf("vec%0d idle_after", i), 32'(idle_ok), 32'd1);
        end

        // req held high: accepts every 4 cycles, response in the last cycle of each group
        we = 1'b0; addr = 32'h10; wdata = 0; be = 4'hF;
        req2 = 1'b1;
        nresp = 0; bad = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp_v = ((k % 4) == 3);
            if (vld2 !== exp_v) bad++;
            if (rdy2 !== ((k % 4) == 0)) bad++;
            if (vld2 === 1'b1) begin
                nresp++;
                if (rd2 !== 32'hDEADBEEF) bad++;
            end
        end
        req2 = 1'b0;
        tail = 0;
        repeat (5) begin
            @(negedge clk);
            if (vld2 !== 1'b0) tail++;
        end
        chk("hold response count", 32'(nresp), 32'd4);
        chk("hold pattern errors", 32'(bad), 32'd0);
        chk("hold tail responses", 32'(tail), 32'd0);

        // reset during WAIT of a store: dropped, not committed
        we = 1'b1; addr = 32'h20; wdata = 32'hA5A5A5A5; be = 4'hF;
        req2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req2 = 1'b0;
        chk("midreset busy before", 32'(rdy2), 32'd0);
        #1 reset_ni = 1'b0;
        #1;
        chk("midreset ready immediate", 32'(rdy2), 32'd1);
        chk("midreset valid immediate", 32'(vld2), 32'd0);
        tail = 0;
        repeat (3) begin
            @(negedge clk);
            if (vld2 !== 1'b0) tail++;
        end
        reset_ni = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (vld2 !== 1'b0) tail++;
        end
        chk("midreset no response", 32'(tail), 32'd0);
        xact(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat, rdy1, idle_ok);
        chk("midreset prior contents", rd, 32'h0BADF00D);
        chk("midreset load err", 32'(er), 32'd0);

        // LATENCY=0 instance
        xact(1'b0, 1'b1, 32'h0, 32'h0000_1234, 4'hF, rd, er, lat, rdy1, idle_ok);
        chk("lat0 store latency", 32'(lat), 32'd1);
        chk("lat0 store busy", 32'(rdy1), 32'd0);
        chk("lat0 store idle_after", 32'(idle_ok), 32'd1);
        chk("lat0 store rdata", rd, 32'd0);
        xact(1'b0, 1'b0, 32'h0, 32'h0, 4'hF, rd, er, lat, rdy1, idle_ok);
        chk("lat0 load latency", 32'(lat), 32'd1);
        chk("lat0 load rdata", rd, 32'h0000_1234);
        chk("lat0 load err", 32'(er), 32'd0);
        chk("lat0 load idle_after", 32'(idle_ok), 32'd1);
        xact(1'b0, 1'b0, 32'h102, 32'h0, 4'hF, rd, er, lat, rdy1, idle_ok);
        chk("lat0 misaligned err", 32'(er), 32'd1);
        chk("lat0 misaligned rdata", rd, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
